// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 state encodings, keyboard command/response codes and frame builder.
// Shared between the host transmitter and the zxkbd receiver.
package ps2_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_INHIBIT  = 3'd1;
   localparam logic [2:0] ST_REQ      = 3'd2;
   localparam logic [2:0] ST_SHIFT    = 3'd3;
   localparam logic [2:0] ST_ACK      = 3'd4;
   localparam logic [2:0] ST_WAITIDLE = 3'd5;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;

   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_RESEND = 8'hFE;

   localparam int LED_SCROLL = 0;
   localparam int LED_NUM    = 1;
   localparam int LED_CAPS   = 2;

   // {stop, odd parity, data}; shifted out LSB first
   function automatic logic [9:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus glitch filter for a PS/2 line.
// level changes only after FILTER_LEN consecutive differing samples; fall pulses on 1->0.
module ps2_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic line_i,
   output logic level,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] run_q, run_d;
   logic          level_q, level_d;
   logic          fall_q, fall_d;
   logic          diff, flip;

   always_comb begin
      sync_d  = {sync_q[0], line_i};
      diff    = sync_q[1] != level_q;
      flip    = diff && run_q == CW'(FILTER_LEN - 1);
      run_d   = (diff && !flip) ? run_q + 1'b1 : '0;
      level_d = flip ? sync_q[1] : level_q;
      fall_d  = flip && level_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         run_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         run_q   <= run_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter on the shared open-collector lines.
// Holds rx_inhibit while it owns the bus so the receiver ignores the outgoing frame.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 1400,
   parameter int TIMEOUT_CYCLES = 210000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int CW = 18;
   localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d, bit_n;
   logic [9:0]    frame_q, frame_d;
   logic [1:0]    dsync_q, dsync_d;
   logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
   logic          done_q, done_d, error_q, error_d;
   logic          clk_lvl, clk_fall, data_s, expired;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
      .clk    (clk),
      .reset  (reset),
      .line_i (ps2_clk_i),
      .level  (clk_lvl),
      .fall   (clk_fall)
   );

   assign data_s  = dsync_q[1];
   assign expired = cnt_q == '0;
   // busy spans the done/error pulse so a start in that cycle is dropped
   assign tx_busy = state_q != ST_IDLE || done_q || error_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      frame_d   = frame_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      dsync_d   = {dsync_q[0], ps2_data_i};
      bit_n     = bit_q + 4'd1;
      case (state_q)
         ST_IDLE: if (tx_start && !tx_busy) begin
            state_d  = ST_INHIBIT;
            frame_d  = ps2_frame(tx_data);
            cnt_d    = INH_LD;
            clk_oe_d = 1'b1;
         end
         ST_INHIBIT: if (expired) begin
            state_d   = ST_REQ;
            cnt_d     = TMO_LD;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
         end else cnt_d = cnt_q - 1'b1;
         default: if (expired) begin
            state_d   = ST_IDLE;
            error_d   = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
            case (state_q)
               ST_REQ: if (clk_fall) begin
                  state_d   = ST_SHIFT;
                  bit_d     = 4'd0;
                  data_oe_d = ~frame_q[0];
                  cnt_d     = TMO_LD;
               end
               ST_SHIFT: if (clk_fall) begin
                  bit_d     = bit_n;
                  data_oe_d = ~frame_q[bit_n];
                  cnt_d     = TMO_LD;
                  state_d   = (bit_n == 4'd9) ? ST_ACK : ST_SHIFT;
               end
               ST_ACK: if (clk_fall) begin
                  cnt_d   = TMO_LD;
                  error_d = data_s;
                  state_d = data_s ? ST_IDLE : ST_WAITIDLE;
               end
               ST_WAITIDLE: if (clk_lvl && data_s) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         frame_q   <= '0;
         dsync_q   <= 2'b11;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         frame_q   <= frame_d;
         dsync_q   <= dsync_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign tx_done     = done_q;
   assign tx_error    = error_q;
   assign rx_inhibit  = tx_busy;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model on wired-AND lines.
// Device clock half-period is scaled down to H system cycles; timeout is shortened.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 1400;
   localparam int TMO = 1000;
   localparam int H   = 40;

   logic       clk = 1'b0, reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe;
   logic       bfm_clk_low = 1'b0, bfm_data_low = 1'b0;
   logic       clk_line, data_line;
   int         n_vec = 0, n_err = 0, n_done = 0, n_errp = 0, n_fall = 0;
   logic [7:0] vd [3] = '{8'h01, 8'h00, 8'hFF};
   logic       vp [3] = '{1'b0, 1'b1, 1'b1};

   assign clk_line  = ~ps2_clk_oe & ~bfm_clk_low;
   assign data_line = ~ps2_data_oe & ~bfm_data_low;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error),
      .rx_inhibit  (rx_inhibit),
      .ps2_clk_i   (clk_line),
      .ps2_data_i  (data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) n_done++;
      if (tx_error) n_errp++;
      if (dut.u_clk_flt.fall) n_fall++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // request a frame and return how many cycles the host held the clock low
   task automatic start_frame(input logic [7:0] d, input bit poke, output int n);
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      n = 0;
      while (ps2_clk_oe && n < 3 * INH) begin
         if (poke && n == 100) begin
            tx_data  = 8'h00;
            tx_start = 1'b1;
         end else tx_start = 1'b0;
         n++;
         @(negedge clk);
      end
      tx_start = 1'b0;
   endtask

   task automatic device(input int nclk, input bit ack_low, output logic [9:0] bits);
      bits = '0;
      for (int i = 1; i <= nclk; i++) begin
         if (i == 11 && ack_low) bfm_data_low = 1'b1;
         repeat (H) @(negedge clk);
         bfm_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         if (i <= 10) bits[i-1] = data_line;
         bfm_clk_low = 1'b0;
      end
      repeat (H) @(negedge clk);
      bfm_data_low = 1'b0;
   endtask

   task automatic wait_idle();
      int m = 0;
      while (tx_busy && m < 4 * TMO) begin
         @(negedge clk);
         m++;
      end
      check("idle_bound", tx_busy, 0);
   endtask

   initial begin
      logic [9:0] bits;
      int n, m, d0, e0, f0;
      repeat (3) @(negedge clk);
      check("reset_outs", {tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // 1: LED command, full handshake, start dropped during the done pulse
      d0 = n_done;
      start_frame(CMD_SET_LED, 1'b0, n);
      check("inhibit_len", n, INH);
      check("start_bit", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      check("busy_inhibit", {tx_busy, rx_inhibit}, 2'b11);
      f0 = n_fall;
      device(11, 1'b1, bits);
      check("frame_ED", bits, 10'b11_1110_1101);
      m = 0;
      while (!tx_done && m < 200) begin
         @(negedge clk);
         m++;
      end
      check("done_ED", tx_done, 1);
      check("busy_at_done", tx_busy, 1);
      tx_data  = CMD_RESET;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (20) @(negedge clk);
      check("start_at_done_dropped", {tx_busy, ps2_clk_oe}, 0);
      check("falls_ED", n_fall - f0, 11);
      check("done_count_ED", n_done - d0, 1);

      // 2: parity patterns
      for (int i = 0; i < 3; i++) begin
         d0 = n_done;
         start_frame(vd[i], 1'b0, n);
         device(11, 1'b1, bits);
         wait_idle();
         check($sformatf("frame_%h", vd[i]), bits, {1'b1, vp[i], vd[i]});
         check($sformatf("done_%h", vd[i]), n_done - d0, 1);
      end

      // 3: silent device -> timeout measured from request
      e0 = n_errp;
      start_frame(CMD_RESET, 1'b0, n);
      m = 0;
      while (!tx_error && m < 4 * TMO) begin
         @(negedge clk);
         m++;
      end
      check("timeout_len", m, TMO);
      check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      wait_idle();
      check("timeout_err", n_errp - e0, 1);

      // 4: device stalls after 5 clocks, then a clean enable command
      e0 = n_errp;
      d0 = n_done;
      start_frame(8'h55, 1'b0, n);
      device(5, 1'b1, bits);
      wait_idle();
      check("stall_err", n_errp - e0, 1);
      check("stall_nodone", n_done - d0, 0);
      d0 = n_done;
      start_frame(CMD_ENABLE, 1'b0, n);
      device(11, 1'b1, bits);
      wait_idle();
      check("frame_F4", bits, 10'b10_1111_0100);
      check("done_F4", n_done - d0, 1);

      // 5: no ACK from device, second start while busy ignored
      e0 = n_errp;
      d0 = n_done;
      start_frame(8'h3C, 1'b1, n);
      device(11, 1'b0, bits);
      wait_idle();
      check("frame_3C_kept", bits, 10'b11_0011_1100);
      check("nack_err", n_errp - e0, 1);
      check("nack_nodone", n_done - d0, 0);
      repeat (20) @(negedge clk);
      check("no_requeue", {tx_busy, ps2_clk_oe}, 0);

      // 6: reset mid-SHIFT releases the lines immediately
      start_frame(8'h00, 1'b0, n);
      for (int i = 0; i < 3; i++) begin
         repeat (H) @(negedge clk);
         bfm_clk_low = 1'b1;
         repeat (H) @(negedge clk);
      end
      check("shift_data_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      #1 reset = 1'b1;
      #1 check("reset_mid_oe", {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
      bfm_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      f0 = n_fall;
      for (int i = 0; i < 3; i++) begin
         bfm_clk_low = 1'b1;
         repeat (2) @(negedge clk);
         bfm_clk_low = 1'b0;
         repeat (10) @(negedge clk);
      end
      check("glitch_falls", n_fall - f0, 0);
      f0 = n_fall;
      bfm_clk_low = 1'b1;
      repeat (6) @(negedge clk);
      bfm_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      check("real_fall", n_fall - f0, 1);
      check("idle_after_falls", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
